int_ctrl: RTL and testbench

Parametrised interrupt controller for the monocycle CPU.
- Replaces the single s_interrup wire with N_CH edge-triggered request channels: pending latches, mask register, fixed priority, in-service tracking and a vector address for the PC mux.
- Drives s_interrup into the control unit for exactly the push cycle.
- Retires service on the control unit's finInterrup strobe.

---
 rtl/int_ctrl_if.sv | 40 ++++
 rtl/int_ctrl.sv | 137 +++++++++++++
 tb/tb_int_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: signal bundle between the CPU/control unit and the interrupt
// controller.
//   irq_in      raw rising-edge request lines, already synchronous to clk
//   mask_we     mask register write strobe
//   mask_din    new mask value (1 = channel masked)
//   finInterrup one-cycle return-from-interrupt strobe from the control unit
//   s_interrup  one-cycle dispatch pulse to the control unit
//   vec_addr    vector address for the PC mux
//   active_ch   channel being dispatched, or highest-priority one in service
//   pend        pending register
//   in_service  in-service register
//   mask        mask register
// Modports: master = CPU side (drives requests/strobes), slave = controller.
interface int_ctrl_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned VEC_W = 10
);
    localparam int unsigned CH_W = $clog2(N_CH);

    logic [N_CH-1:0]  irq_in;
    logic             mask_we;
    logic [N_CH-1:0]  mask_din;
    logic             finInterrup;
    logic             s_interrup;
    logic [VEC_W-1:0] vec_addr;
    logic [CH_W-1:0]  active_ch;
    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  in_service;
    logic [N_CH-1:0]  mask;

    modport master (
        output irq_in, mask_we, mask_din, finInterrup,
        input  s_interrup, vec_addr, active_ch, pend, in_service, mask
    );

    modport slave (
        input  irq_in, mask_we, mask_din, finInterrup,
        output s_interrup, vec_addr, active_ch, pend, in_service, mask
    );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: parametrised interrupt controller for the monocycle CPU.
// N_CH rising-edge request channels with pending latches, a mask register,
// fixed priority (channel 0 highest), in-service tracking and a vector
// address (VEC_BASE + active_ch*VEC_STRIDE, wrapping at VEC_W bits).
// s_interrup is high for exactly the cycle the control unit pushes the PC;
// service is retired by the finInterrup strobe.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high reset
//   bus    int_ctrl_if.slave (requests, mask, strobes, status outputs)
// Build option: define INT_NEST_EN to let a strictly higher-priority
// eligible channel preempt the one currently in service.
module int_ctrl #(
    parameter int unsigned           N_CH       = 4,
    parameter int unsigned           VEC_W      = 10,
    parameter logic [VEC_W-1:0]      VEC_BASE   = 10'h3C0,
    parameter int unsigned           VEC_STRIDE = 4
) (
    input  logic        clk,
    input  logic        reset,
    int_ctrl_if.slave   bus
);
    localparam int unsigned     CH_W = $clog2(N_CH);
    localparam logic [N_CH-1:0] ONE  = N_CH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        SERVICE
    } state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  enter_ch_q, enter_ch_d;
    logic [N_CH-1:0]  irq_q;
    logic [N_CH-1:0]  pend_q;
    logic [N_CH-1:0]  in_service_q;
    logic [N_CH-1:0]  mask_q;

    logic [N_CH-1:0]  irq_rise;
    logic [N_CH-1:0]  eligible;
    logic             elig_any;
    logic [CH_W-1:0]  elig_ch;
    logic [CH_W-1:0]  svc_ch;
    logic [N_CH-1:0]  dispatch;
    logic [N_CH-1:0]  retire;
    logic             s_int;
    logic [CH_W-1:0]  act_ch;

    // Index of the lowest set bit (highest priority); 0 when none set.
    function automatic logic [CH_W-1:0] lowest(input logic [N_CH-1:0] v);
        logic [CH_W-1:0] r;
        r = '0;
        for (int unsigned i = N_CH; i > 0; i--) begin
            if (v[i-1]) r = CH_W'(i - 1);
        end
        return r;
    endfunction

    assign irq_rise = bus.irq_in & ~irq_q;
    assign eligible = pend_q & ~mask_q;
    assign elig_any = |eligible;
    assign elig_ch  = lowest(eligible);
    assign svc_ch   = lowest(in_service_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            enter_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            enter_ch_q <= enter_ch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        enter_ch_d = enter_ch_q;
        dispatch   = '0;
        retire     = '0;
        s_int      = 1'b0;
        act_ch     = '0;
        case (state_q)
            IDLE: begin
                if (elig_any) begin
                    state_d    = ENTER;
                    enter_ch_d = elig_ch;
                end
            end
            ENTER: begin
                // finInterrup is deliberately ignored here.
                s_int    = 1'b1;
                act_ch   = enter_ch_q;
                dispatch = ONE << enter_ch_q;
                state_d  = SERVICE;
            end
            SERVICE: begin
                act_ch = svc_ch;
                if (bus.finInterrup) begin
                    // Retire takes precedence; any new dispatch is decided
                    // on the following cycle.
                    retire = ONE << svc_ch;
                    if ((in_service_q & ~retire) == '0) state_d = IDLE;
                end
`ifdef INT_NEST_EN
                else if (elig_any && (elig_ch < svc_ch)) begin
                    state_d    = ENTER;
                    enter_ch_d = elig_ch;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // The edge history is loaded during reset too, so lines already high at
    // reset never look like a fresh request afterwards.
    always_ff @(posedge clk) begin
        irq_q <= bus.irq_in;
        if (reset) begin
            pend_q       <= '0;
            in_service_q <= '0;
            mask_q       <= '1;
        end else begin
            // A new edge on the channel being entered wins over its clear.
            pend_q       <= (pend_q & ~dispatch) | irq_rise;
            in_service_q <= (in_service_q | dispatch) & ~retire;
            if (bus.mask_we) mask_q <= bus.mask_din;
        end
    end

    assign bus.s_interrup = s_int;
    assign bus.active_ch  = act_ch;
    assign bus.vec_addr   = VEC_BASE + VEC_W'(act_ch) * VEC_W'(VEC_STRIDE);
    assign bus.pend       = pend_q;
    assign bus.in_service = in_service_q;
    assign bus.mask       = mask_q;
endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    int_ctrl_if #(.N_CH(4), .VEC_W(10)) bus ();

    int_ctrl #(
        .N_CH(4),
        .VEC_W(10),
        .VEC_BASE(10'h3C0),
        .VEC_STRIDE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.irq_in = 4'b0000;
        bus.mask_we = 1'b0;
        bus.mask_din = 4'b0000;
        bus.finInterrup = 1'b0;
        tick();
        tick();
        checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL rst_pend: got %b exp %b", bus.pend, 4'b0000); end
        checks++; if (bus.in_service !== 4'b0000) begin errors++; $display("FAIL rst_insvc: got %b exp %b", bus.in_service, 4'b0000); end
        checks++; if (bus.mask !== 4'b1111) begin errors++; $display("FAIL rst_mask: got %b exp %b", bus.mask, 4'b1111); end
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL rst_sint: got %b exp %b", bus.s_interrup, 1'b0); end
        checks++; if (bus.active_ch !== 2'd0) begin errors++; $display("FAIL rst_act: got %0d exp %0d", bus.active_ch, 0); end
        checks++; if (bus.vec_addr !== 10'h3C0) begin errors++; $display("FAIL rst_vec: got %h exp %h", bus.vec_addr, 10'h3C0); end
        reset = 1'b0;
        bus.mask_we = 1'b1;
        bus.mask_din = 4'b0000;
        tick();
        bus.mask_we = 1'b0;
        checks++; if (bus.mask !== 4'b0000) begin errors++; $display("FAIL rst_maskwr: got %b exp %b", bus.mask, 4'b0000); end
    endtask

    task automatic test_single();
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = 4'b0000;
        checks++; if (bus.pend !== 4'b0100) begin errors++; $display("FAIL single_pend: got %b exp %b", bus.pend, 4'b0100); end
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL single_early: got %b exp %b", bus.s_interrup, 1'b0); end
        tick();
        checks++; if (bus.s_interrup !== 1'b1) begin errors++; $display("FAIL single_sint: got %b exp %b", bus.s_interrup, 1'b1); end
        checks++; if (bus.active_ch !== 2'd2) begin errors++; $display("FAIL single_act: got %0d exp %0d", bus.active_ch, 2); end
        checks++; if (bus.vec_addr !== 10'h3C8) begin errors++; $display("FAIL single_vec: got %h exp %h", bus.vec_addr, 10'h3C8); end
        tick();
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b exp %b", bus.s_interrup, 1'b0); end
        checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL single_pclr: got %b exp %b", bus.pend, 4'b0000); end
        checks++; if (bus.in_service !== 4'b0100) begin errors++; $display("FAIL single_insvc: got %b exp %b", bus.in_service, 4'b0100); end
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
        checks++; if (bus.in_service !== 4'b0000) begin errors++; $display("FAIL single_ret: got %b exp %b", bus.in_service, 4'b0000); end
        tick();
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp %b", bus.s_interrup, 1'b0); end
    endtask

    task automatic test_priority();
        bus.irq_in = 4'b1010;
        tick();
        bus.irq_in = 4'b0000;
        checks++; if (bus.pend !== 4'b1010) begin errors++; $display("FAIL prio_pend: got %b exp %b", bus.pend, 4'b1010); end
        tick();
        checks++; if (bus.active_ch !== 2'd1) begin errors++; $display("FAIL prio_act1: got %0d exp %0d", bus.active_ch, 1); end
        checks++; if (bus.vec_addr !== 10'h3C4) begin errors++; $display("FAIL prio_vec1: got %h exp %h", bus.vec_addr, 10'h3C4); end
        tick();
        tick();
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL prio_hold: got %b exp %b", bus.s_interrup, 1'b0); end
        checks++; if (bus.pend !== 4'b1000) begin errors++; $display("FAIL prio_pend3: got %b exp %b", bus.pend, 4'b1000); end
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL prio_retsint: got %b exp %b", bus.s_interrup, 1'b0); end
        tick();
        checks++; if (bus.s_interrup !== 1'b1) begin errors++; $display("FAIL prio_sint3: got %b exp %b", bus.s_interrup, 1'b1); end
        checks++; if (bus.vec_addr !== 10'h3CC) begin errors++; $display("FAIL prio_vec3: got %h exp %h", bus.vec_addr, 10'h3CC); end
        tick();
        checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL prio_pend0: got %b exp %b", bus.pend, 4'b0000); end
        checks++; if (bus.in_service !== 4'b1000) begin errors++; $display("FAIL prio_insvc3: got %b exp %b", bus.in_service, 4'b1000); end
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
    endtask

    task automatic test_mask();
        bus.mask_we = 1'b1;
        bus.mask_din = 4'b0001;
        tick();
        bus.mask_we = 1'b0;
        bus.irq_in = 4'b0001;
        tick();
        bus.irq_in = 4'b0000;
        tick();
        tick();
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b exp %b", bus.s_interrup, 1'b0); end
        checks++; if (bus.pend !== 4'b0001) begin errors++; $display("FAIL mask_pend: got %b exp %b", bus.pend, 4'b0001); end
        bus.mask_we = 1'b1;
        bus.mask_din = 4'b0000;
        tick();
        bus.mask_we = 1'b0;
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL mask_samecyc: got %b exp %b", bus.s_interrup, 1'b0); end
        tick();
        checks++; if (bus.s_interrup !== 1'b1) begin errors++; $display("FAIL mask_disp: got %b exp %b", bus.s_interrup, 1'b1); end
        checks++; if (bus.vec_addr !== 10'h3C0) begin errors++; $display("FAIL mask_vec: got %h exp %h", bus.vec_addr, 10'h3C0); end
        tick();
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
    endtask

    task automatic test_enter_collision();
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = 4'b0000;
        tick();
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = 4'b0000;
        checks++; if (bus.pend !== 4'b0100) begin errors++; $display("FAIL coll_pend: got %b exp %b", bus.pend, 4'b0100); end
        checks++; if (bus.in_service !== 4'b0100) begin errors++; $display("FAIL coll_insvc: got %b exp %b", bus.in_service, 4'b0100); end
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
        tick();
        checks++; if (bus.s_interrup !== 1'b1) begin errors++; $display("FAIL coll_redisp: got %b exp %b", bus.s_interrup, 1'b1); end
        tick();
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
    endtask

    task automatic test_nesting();
        bus.irq_in = 4'b1000;
        tick();
        bus.irq_in = 4'b0000;
        tick();
        tick();
        checks++; if (bus.in_service !== 4'b1000) begin errors++; $display("FAIL nest_svc3: got %b exp %b", bus.in_service, 4'b1000); end
        bus.irq_in = 4'b0001;
        tick();
        bus.irq_in = 4'b0000;
        tick();
`ifdef INT_NEST_EN
        checks++; if (bus.s_interrup !== 1'b1) begin errors++; $display("FAIL nest_pre: got %b exp %b", bus.s_interrup, 1'b1); end
        checks++; if (bus.active_ch !== 2'd0) begin errors++; $display("FAIL nest_act: got %0d exp %0d", bus.active_ch, 0); end
        tick();
        checks++; if (bus.in_service !== 4'b1001) begin errors++; $display("FAIL nest_both: got %b exp %b", bus.in_service, 4'b1001); end
        bus.finInterrup = 1'b1;
        tick();
        checks++; if (bus.in_service !== 4'b1000) begin errors++; $display("FAIL nest_ret0: got %b exp %b", bus.in_service, 4'b1000); end
        checks++; if (bus.active_ch !== 2'd3) begin errors++; $display("FAIL nest_act3: got %0d exp %0d", bus.active_ch, 3); end
        tick();
        bus.finInterrup = 1'b0;
        checks++; if (bus.in_service !== 4'b0000) begin errors++; $display("FAIL nest_ret3: got %b exp %b", bus.in_service, 4'b0000); end
`else
        tick();
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL nest_nopre: got %b exp %b", bus.s_interrup, 1'b0); end
        checks++; if (bus.pend !== 4'b0001) begin errors++; $display("FAIL nest_pend: got %b exp %b", bus.pend, 4'b0001); end
        checks++; if (bus.active_ch !== 2'd3) begin errors++; $display("FAIL nest_act3: got %0d exp %0d", bus.active_ch, 3); end
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
        checks++; if (bus.in_service !== 4'b0000) begin errors++; $display("FAIL nest_ret3: got %b exp %b", bus.in_service, 4'b0000); end
        tick();
        checks++; if (bus.s_interrup !== 1'b1) begin errors++; $display("FAIL nest_late: got %b exp %b", bus.s_interrup, 1'b1); end
        checks++; if (bus.active_ch !== 2'd0) begin errors++; $display("FAIL nest_late_act: got %0d exp %0d", bus.active_ch, 0); end
        tick();
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
`endif
    endtask

    task automatic test_held_at_reset();
        bus.irq_in = 4'b0010;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.mask_we = 1'b1;
        bus.mask_din = 4'b0000;
        tick();
        bus.mask_we = 1'b0;
        tick();
        tick();
        checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL held_pend: got %b exp %b", bus.pend, 4'b0000); end
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL held_sint: got %b exp %b", bus.s_interrup, 1'b0); end
        bus.irq_in = 4'b0000;
        tick();
        bus.irq_in = 4'b0010;
        tick();
        checks++; if (bus.pend !== 4'b0010) begin errors++; $display("FAIL held_newedge: got %b exp %b", bus.pend, 4'b0010); end
        tick();
        checks++; if (bus.s_interrup !== 1'b1) begin errors++; $display("FAIL held_disp: got %b exp %b", bus.s_interrup, 1'b1); end
        checks++; if (bus.active_ch !== 2'd1) begin errors++; $display("FAIL held_act: got %0d exp %0d", bus.active_ch, 1); end
        bus.irq_in = 4'b0000;
        tick();
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
    endtask

    task automatic test_reset_mid_service();
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = 4'b0000;
        tick();
        tick();
        bus.irq_in = 4'b1000;
        tick();
        bus.irq_in = 4'b0000;
        checks++; if (bus.pend !== 4'b1000) begin errors++; $display("FAIL mid_pend: got %b exp %b", bus.pend, 4'b1000); end
        checks++; if (bus.in_service !== 4'b0100) begin errors++; $display("FAIL mid_insvc: got %b exp %b", bus.in_service, 4'b0100); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL mid_rpend: got %b exp %b", bus.pend, 4'b0000); end
        checks++; if (bus.in_service !== 4'b0000) begin errors++; $display("FAIL mid_rinsvc: got %b exp %b", bus.in_service, 4'b0000); end
        checks++; if (bus.mask !== 4'b1111) begin errors++; $display("FAIL mid_rmask: got %b exp %b", bus.mask, 4'b1111); end
        checks++; if (bus.vec_addr !== 10'h3C0) begin errors++; $display("FAIL mid_rvec: got %h exp %h", bus.vec_addr, 10'h3C0); end
        bus.finInterrup = 1'b1;
        tick();
        bus.finInterrup = 1'b0;
        tick();
        checks++; if (bus.in_service !== 4'b0000) begin errors++; $display("FAIL stray_insvc: got %b exp %b", bus.in_service, 4'b0000); end
        checks++; if (bus.s_interrup !== 1'b0) begin errors++; $display("FAIL stray_sint: got %b exp %b", bus.s_interrup, 1'b0); end
        checks++; if (bus.active_ch !== 2'd0) begin errors++; $display("FAIL stray_act: got %0d exp %0d", bus.active_ch, 0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_enter_collision();
        test_nesting();
        test_held_at_reset();
        test_reset_mid_service();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
